// File: rtl/high_score_pkg.sv
// Shared types and defaults for the high-score tracker slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package high_score_pkg;

   localparam int DEF_DIGITS      = 2;
   localparam int DEF_ADDR_W      = 6;
   localparam int DEF_RD_LAT      = 4;
   localparam int DEF_GUEST_ADDR  = 40;
   localparam int DEF_GLOBAL_ADDR = 40;

   typedef logic [3:0] bcdDigit_t;

   typedef enum logic [3:0] {
      IDLE,
      ARMED,
      READ_USER,
      CMP_USER,
      WRITE_USER,
      READ_GLOBAL,
      CMP_GLOBAL,
      WRITE_GLOBAL,
      DONE
   } trackerState_t;

   function automatic logic isBcd(input bcdDigit_t d);
      return d <= 4'd9;
   endfunction

endpackage

// File: rtl/score_ram_port.sv
// Digit sequencer: reads or writes one DIGITS-long BCD record on the score RAM.
// Latency: read DIGITS*(RD_LAT+1) cycles, write 3*DIGITS cycles; opDone in the last cycle.
// Backpressure: none; a start pulse always (re)launches an operation.
// Ports: start/base/writeMode/wrVec launch an op; rdVec holds read digits (MSD in top
// nibble); ram_addr/ram_wdata/ram_we drive the RAM, ram_rdata returns its data.
module score_ram_port
   import high_score_pkg::*;
#(
   parameter int DIGITS = DEF_DIGITS,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                writeMode,
   input  logic [ADDR_W-1:0]   base,
   input  logic [4*DIGITS-1:0] wrVec,
   output logic [4*DIGITS-1:0] rdVec,
   output logic                opDone,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [3:0]          ram_wdata,
   output logic                ram_we,
   input  logic [3:0]          ram_rdata
);
   localparam int SUB_W = $clog2(RD_LAT + 3);
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SUB_W-1:0] RD_LAST  = SUB_W'(RD_LAT);
   localparam logic [SUB_W-1:0] WR_LAST  = SUB_W'(2);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

   logic                active;
   logic                isWrite;
   logic [SUB_W-1:0]    subCnt;
   logic [DIG_W-1:0]    digCnt;
   logic [4*DIGITS-1:0] wrVecQ;
   logic                digitEnd;

   // Digit d of a record lives in nibble DIGITS-1-d (most significant first).
   function automatic bcdDigit_t pick(input logic [4*DIGITS-1:0] v, input logic [DIG_W-1:0] d);
      return v[4*(DIGITS-1-int'(d)) +: 4];
   endfunction

   assign digitEnd = (subCnt == (isWrite ? WR_LAST : RD_LAST));
   assign opDone   = active && digitEnd && (digCnt == DIG_LAST);

   // Address/data are registered and only move on a digit boundary, so the RAM
   // sees a stable address for the whole read window and across the we pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         active    <= 1'b0;
         isWrite   <= 1'b0;
         subCnt    <= '0;
         digCnt    <= '0;
         wrVecQ    <= '0;
         rdVec     <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else if (start) begin
         active    <= 1'b1;
         isWrite   <= writeMode;
         subCnt    <= '0;
         digCnt    <= '0;
         wrVecQ    <= wrVec;
         ram_addr  <= base;
         ram_wdata <= writeMode ? wrVec[4*DIGITS-1 -: 4] : 4'd0;
         ram_we    <= 1'b0;
      end else if (active) begin
         subCnt <= subCnt + SUB_W'(1);
         if (isWrite) begin
            // setup / strobe / hold: we is high only in the middle cycle
            ram_we <= (subCnt == '0);
         end else if (digitEnd) begin
            rdVec[4*(DIGITS-1-int'(digCnt)) +: 4] <= ram_rdata;
         end
         if (digitEnd) begin
            subCnt <= '0;
            if (digCnt == DIG_LAST) begin
               active <= 1'b0;
            end else begin
               digCnt   <= digCnt + DIG_W'(1);
               ram_addr <= ram_addr + ADDR_W'(1);
               if (isWrite) ram_wdata <= pick(wrVecQ, digCnt + DIG_W'(1));
            end
         end
      end
   end

endmodule

// File: rtl/high_score_tracker.sv
// High-score tracker: on game-over compares the final BCD score with the user's and global records, rewrites beaten ones.
// Latency: 12..35 cycles from game_over to done (DIGITS=2, RD_LAT=4); done is a one-cycle pulse.
// Backpressure: none; game_start/game_over are ignored while busy.
// Ports: game_start/game_over/user_addr/score from game+auth; ram_* to the single-port score RAM;
// disp_score/disp_global/new_personal/new_global held results; busy/done status.
module high_score_tracker
   import high_score_pkg::*;
#(
   parameter int DIGITS      = DEF_DIGITS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int GUEST_ADDR  = DEF_GUEST_ADDR,
   parameter int GLOBAL_ADDR = DEF_GLOBAL_ADDR,
   parameter int RD_LAT      = DEF_RD_LAT,
   parameter int TIE_UPDATES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                game_start,
   input  logic                game_over,
   input  logic [ADDR_W-1:0]   user_addr,
   input  logic [4*DIGITS-1:0] score,
   input  logic [3:0]          ram_rdata,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [3:0]          ram_wdata,
   output logic                ram_we,
   output logic [4*DIGITS-1:0] disp_score,
   output logic                disp_global,
   output logic                new_personal,
   output logic                new_global,
   output logic                busy,
   output logic                done
);
   localparam logic [ADDR_W-1:0] GUEST_BASE  = ADDR_W'(GUEST_ADDR);
   localparam logic [ADDR_W-1:0] GLOBAL_BASE = ADDR_W'(GLOBAL_ADDR);

   trackerState_t       state, nextState;
   logic [ADDR_W-1:0]   userAddrQ;
   logic [4*DIGITS-1:0] scoreQ;
   logic [4*DIGITS-1:0] storedRec;
   logic                seqStart, seqWrite, seqDone;
   logic [ADDR_W-1:0]   seqBase;
   logic                invalid, beaten;

   score_ram_port #(
      .DIGITS(DIGITS),
      .ADDR_W(ADDR_W),
      .RD_LAT(RD_LAT)
   ) ramPort (
      .clk      (clk),
      .rst      (rst),
      .start    (seqStart),
      .writeMode(seqWrite),
      .base     (seqBase),
      .wrVec    (scoreQ),
      .rdVec    (storedRec),
      .opDone   (seqDone),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_we   (ram_we),
      .ram_rdata(ram_rdata)
   );

   // BCD vectors of valid digits order the same way as the numbers they encode,
   // so a whole-vector unsigned compare gives the numeric result.
   always_comb begin
      invalid = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (!isBcd(storedRec[4*d +: 4])) invalid = 1'b1;
      end
      beaten = invalid || (scoreQ > storedRec) ||
               ((TIE_UPDATES != 0) && (scoreQ == storedRec));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:         if (game_start) nextState = ARMED;
         ARMED:        if (game_over)
                          nextState = (user_addr != GUEST_BASE) ? READ_USER : READ_GLOBAL;
         READ_USER:    if (seqDone) nextState = CMP_USER;
         CMP_USER:     nextState = beaten ? WRITE_USER : DONE;
         WRITE_USER:   if (seqDone) nextState = READ_GLOBAL;
         READ_GLOBAL:  if (seqDone) nextState = CMP_GLOBAL;
         CMP_GLOBAL:   nextState = beaten ? WRITE_GLOBAL : DONE;
         WRITE_GLOBAL: if (seqDone) nextState = DONE;
         DONE:         nextState = IDLE;
         default:      nextState = IDLE;
      endcase
   end

   // The sequencer is launched on the edge that enters a RAM state, so that
   // state lasts exactly as long as the sequencer's operation.
   always_comb begin
      seqStart = (nextState != state) &&
                 (nextState inside {READ_USER, WRITE_USER, READ_GLOBAL, WRITE_GLOBAL});
      seqWrite = nextState inside {WRITE_USER, WRITE_GLOBAL};
      if (nextState inside {READ_GLOBAL, WRITE_GLOBAL}) seqBase = GLOBAL_BASE;
      else if (state == ARMED)                            seqBase = user_addr;
      else                                                seqBase = userAddrQ;
      busy = !(state inside {IDLE, ARMED});
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         userAddrQ    <= '0;
         scoreQ       <= '0;
         disp_score   <= '0;
         disp_global  <= 1'b0;
         new_personal <= 1'b0;
         new_global   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (game_start) begin
               disp_score   <= '0;
               disp_global  <= 1'b0;
               new_personal <= 1'b0;
               new_global   <= 1'b0;
            end
            ARMED: if (game_over) begin
               userAddrQ <= user_addr;
               scoreQ    <= score;
            end
            CMP_USER: begin
               if (beaten) begin
                  new_personal <= 1'b1;
               end else begin
                  disp_score  <= storedRec;
                  disp_global <= 1'b0;
               end
            end
            CMP_GLOBAL: begin
               if (beaten) begin
                  new_global  <= 1'b1;
                  disp_score  <= scoreQ;
                  disp_global <= 1'b1;
               end else if (userAddrQ != GUEST_BASE) begin
                  // registered user only gets here after a new personal best
                  disp_score  <= scoreQ;
                  disp_global <= 1'b0;
               end else begin
                  disp_score  <= storedRec;
                  disp_global <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/high_score_tracker.md
# high_score_tracker

Parametrised high-score tracker for the memory-sequence game: on game-over it reads the logged-in user's personal best and the global best from the shared score RAM, compares them against the final BCD score, and writes back whichever records were beaten. It then presents the score to show on the rightmost displays, plus "H"/"G" and new-record flags. It sits between the auth module (user address), the game timer (start/over) and the single-port score RAM.

## Interface
- `DIGITS`, 2: number of BCD digits per score. Records are stored most-significant digit first at consecutive addresses.
- `ADDR_W`, 6: RAM address width.
- `GUEST_ADDR`, 40: user address meaning "guest / nobody logged in".
- `GLOBAL_ADDR`, 40: base address of the global-best record.
- `RD_LAT`, 4: cycles from a stable address to valid `ram_rdata`.
- `TIE_UPDATES`, 1: 1 = an equal score counts as a new record; 0 = strictly greater only.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `game_start` in 1: level or pulse; arms the tracker.
- `game_over` in 1: level or pulse; final score is valid.
- `user_addr` in ADDR_W: base address of the user's personal-best record.
- `score` in 4*DIGITS: final BCD score, most-significant digit in the top nibble.
- `ram_rdata` in 4: RAM read data.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out 4: RAM write data.
- `ram_we` out 1: write strobe.
- `disp_score` out 4*DIGITS: BCD value to display.
- `disp_global` out 1: 1 = show "G", 0 = show "H".
- `new_personal`, `new_global` out 1: record-beaten flags, held until the next `game_start`.
- `busy` out 1: high in every state except IDLE and ARMED.
- `done` out 1: one-cycle pulse when the results are valid.

## Operation
- Reset values: all outputs 0; state IDLE.
- States: IDLE, ARMED, READ_USER, CMP_USER, WRITE_USER, READ_GLOBAL, CMP_GLOBAL, WRITE_GLOBAL, DONE.
- IDLE → ARMED on `game_start`. This transition clears `disp_score`, `disp_global` and both flags. `game_over` is ignored in IDLE.
- ARMED → on `game_over`:
  - READ_USER if `user_addr` != GUEST_ADDR;
  - otherwise READ_GLOBAL.
- `user_addr` and `score` are latched in the same cycle as the ARMED → read transition.
- READ_x: for each digit d = 0..DIGITS-1, drive `ram_addr` = base+d for RD_LAT+1 cycles, capturing `ram_rdata` in the last of those cycles.
- CMP_x (1 cycle): numeric comparison of the whole score, most-significant digit first. This is not per-digit; e.g. 31 beats 29.
  - Beaten means greater than, or greater-or-equal when TIE_UPDATES=1.
  - A stored digit > 9 marks the record invalid; an invalid record is always beaten.
- CMP_USER:
  - if beaten: set `new_personal`, go to WRITE_USER;
  - else: load the stored personal best into `disp_score`, set `disp_global`=0, go to DONE.
- WRITE_USER → READ_GLOBAL.
- CMP_GLOBAL:
  - if beaten: set `new_global`, `disp_score`=score, `disp_global`=1, go to WRITE_GLOBAL.
  - else, registered user: `disp_score`=score, `disp_global`=0 (the new personal best), go to DONE.
  - else, guest: `disp_score` = stored global best, `disp_global`=1, go to DONE.
- WRITE_x → DONE. Per digit, 3 cycles: address and data set with `ram_we`=0, then `ram_we`=1, then `ram_we`=0. Address and data are stable across all three cycles.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `game_start` or `game_over` while busy: ignored.
- `rst` mid-operation: `ram_we`=0 and state IDLE at the next edge. A partially written record is tolerated (the invalid-digit rule covers it).

## Timing
- State durations:
  - READ_x: DIGITS*(RD_LAT+1) cycles.
  - CMP_x: 1 cycle.
  - WRITE_x: 3*DIGITS cycles.
  - DONE: 1 cycle.
- Latency with DIGITS=2, RD_LAT=4, counted from the edge that samples `game_over` (the cycle in which `done` is high):
  - user, no record: 12;
  - user, personal only: 29;
  - user, personal and global: 35;
  - guest, no record: 12;
  - guest, global: 18.
- `disp_*` and the flags are stable from DONE until the next `game_start`.
- The read-phase address is constant for RD_LAT+1 cycles. There is no combinational path from `ram_rdata` to `ram_addr`.

## Structure
- Package `high_score_pkg` holds:
  - the state enum;
  - default DIGITS, RD_LAT, GUEST_ADDR and GLOBAL_ADDR constants;
  - a BCD digit type.
- Sub-module `score_ram_port`: the digit sequencer.
  - Takes a start pulse, base address, read/write mode and write vector.
  - Returns a read vector and a done pulse.
  - Owns `ram_addr`, `ram_we` and `ram_wdata`, and the per-digit counters.
- The top level holds the FSM, the comparator and the display logic.

## Test plan
- Reset mid-WRITE_USER (`ram_we`=1) → next cycle `ram_we`=0, `busy`=0, all outputs 0.
- User at address 10, stored 29, score 31 → RAM[10..11]=3,1; `new_personal`=1. Global at 40 stored 45 → not beaten; `disp_score`=31, `disp_global`=0, `done` at cycle 29.
- User stored 31, score 29 → no writes; `disp_score`=31, `disp_global`=0, `done` at cycle 12.
- Guest, global 45, score 50 → RAM[40..41]=5,0; `new_global`=1, `disp_global`=1; `done` at cycle 18.
- TIE_UPDATES=0, user stored 31, score 31 → no write, `new_personal`=0. With TIE_UPDATES=1 → write occurs.
- Stored digit 0xF, score 00 → record treated as invalid and rewritten to 0,0. `game_start` and `game_over` asserted during this run are ignored.
